// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier requester: FSM encoding, default widths, operand packing offsets.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } mult_state_e;

  localparam int MULT_DATA_WIDTH = 8;
  localparam int TXN_CNT_W       = 16;

  // Operand A rides in the upper half of data_req, operand B in the lower half.
  localparam int OPA_MSB = 2*MULT_DATA_WIDTH - 1;
  localparam int OPA_LSB = MULT_DATA_WIDTH;
  localparam int OPB_MSB = MULT_DATA_WIDTH - 1;
  localparam int OPB_LSB = 0;

endpackage

// File: rtl/mult_req_timer.sv
// WAIT-state ack watchdog: counts cycles spent in WAIT, flags expiry on the TIMEOUT_CYC-th cycle.
// Zero-latency expired output; no backpressure (pure counter).
module mult_req_timer #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign expired = run && (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mult_requester.sv
// Req/ack initiator for the shift-and-add multiplier; accept->req 1 cycle, ack->out_valid 1 cycle.
// One transaction in flight; in_ready low until out_ready drains the product. Optional MULT_REQ_TIMEOUT_EN.
module mult_requester
  import mult_pkg::*;
#(
  parameter int DATA_WIDTH  = MULT_DATA_WIDTH,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_a,
  input  logic [DATA_WIDTH-1:0]   in_b,
  output logic                    req,
  output logic [2*DATA_WIDTH-1:0] data_req,
  input  logic                    ack,
  input  logic [2*DATA_WIDTH-1:0] data_ack,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out_data,
  output logic                    busy,
  output logic [TXN_CNT_W-1:0]    txn_cnt
`ifdef MULT_REQ_TIMEOUT_EN
  ,
  output logic                    timeout_err
`endif
);

  mult_state_e             state_q, state_d;
  logic [2*DATA_WIDTH-1:0] data_req_q, data_req_d;
  logic [2*DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [TXN_CNT_W-1:0]    txn_cnt_q, txn_cnt_d;
  logic                    tmr_expired;

`ifdef MULT_REQ_TIMEOUT_EN
  logic timeout_err_q, timeout_err_d;

  // Entry to WAIT is only ever from ISSUE, so clearing there restarts the count per request.
  mult_req_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_q == ISSUE),
    .run     (state_q == WAIT),
    .expired (tmr_expired)
  );

  assign timeout_err = timeout_err_q;
`else
  logic tmo_unused;
  assign tmo_unused  = (TIMEOUT_CYC > 0);
  assign tmr_expired = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    data_req_d = data_req_q;
    out_data_d = out_data_q;
    txn_cnt_d  = txn_cnt_q;
`ifdef MULT_REQ_TIMEOUT_EN
    timeout_err_d = timeout_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_req_d = {in_a, in_b};
          state_d    = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (ack) begin
          out_data_d = data_ack;
          state_d    = HOLD;
        end else if (tmr_expired) begin
          out_data_d = '1;
`ifdef MULT_REQ_TIMEOUT_EN
          timeout_err_d = 1'b1;
`endif
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          txn_cnt_d = txn_cnt_q + TXN_CNT_W'(1);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      data_req_q <= '0;
      out_data_q <= '0;
      txn_cnt_q  <= '0;
`ifdef MULT_REQ_TIMEOUT_EN
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      data_req_q <= data_req_d;
      out_data_q <= out_data_d;
      txn_cnt_q  <= txn_cnt_d;
`ifdef MULT_REQ_TIMEOUT_EN
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign req       = (state_q == ISSUE);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign data_req  = data_req_q;
  assign out_data  = out_data_q;
  assign txn_cnt   = txn_cnt_q;

endmodule

// File: tb/tb_mult_requester.sv
// Directed bench for mult_requester with a request/product scoreboard; covers MULT_REQ_TIMEOUT_EN when defined.
module tb_mult_requester;
  import mult_pkg::*;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic          req;
  logic [15:0]   data_req;
  logic          ack = 1'b0;
  logic [15:0]   data_ack = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [15:0]   out_data;
  logic          busy;
  logic [15:0]   txn_cnt;
`ifdef MULT_REQ_TIMEOUT_EN
  logic          timeout_err;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [15:0] req_q[$];
  logic [15:0] prod_q[$];

  mult_requester #(
    .DATA_WIDTH  (DW),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .req       (req),
    .data_req  (data_req),
    .ack       (ack),
    .data_ack  (data_ack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .txn_cnt   (txn_cnt)
`ifdef MULT_REQ_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_ops(input logic [DW-1:0] a, input logic [DW-1:0] b);
    @(posedge clk); #1;
    chk("send_in_ready", in_ready, 1);
    in_valid = 1'b1; in_a = a; in_b = b;
    req_q.push_back({a, b});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Expects req on the first negedge after the accepting edge, for exactly one cycle.
  task automatic expect_req(input string tag);
    logic [15:0] e;
    int          lat;
    bit          found;
    found = 1'b0;
    lat   = -1;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (req) begin found = 1'b1; lat = i; end
    end
    chk({tag, "_req_seen"}, 32'(found), 1);
    chk({tag, "_req_lat"}, lat, 0);
    e = (req_q.size() > 0) ? req_q.pop_front() : 16'hxxxx;
    chk({tag, "_data_req"}, data_req, e);
    @(negedge clk);
    chk({tag, "_req_pulse"}, req, 0);
  endtask

  task automatic do_ack(input logic [15:0] d);
    ack = 1'b1; data_ack = d;
    prod_q.push_back(d);
    @(posedge clk); #1;
    ack = 1'b0;
  endtask

  task automatic expect_out(input string tag);
    logic [15:0] e;
    @(negedge clk);
    chk({tag, "_out_valid"}, out_valid, 1);
    e = (prod_q.size() > 0) ? prod_q.pop_front() : 16'hxxxx;
    chk({tag, "_out_data"}, out_data, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_req", req, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data_req", data_req, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_txn_cnt", txn_cnt, 0);
`ifdef MULT_REQ_TIMEOUT_EN
    chk("rst_timeout_err", timeout_err, 0);
`endif
    rst_n = 1'b1;

    // Basic transaction: 13*11, ack 9 cycles after req
    send_ops(8'd13, 8'd11);
    expect_req("basic");
    chk("basic_opa", data_req[OPA_MSB:OPA_LSB], 8'd13);
    chk("basic_busy", busy, 1);
    repeat (8) @(posedge clk); #1;
    do_ack(16'd143);
    expect_out("basic");
    @(negedge clk);
    chk("basic_out_valid_clr", out_valid, 0);
    chk("basic_txn_cnt", txn_cnt, 1);

    // Backpressure with a second operand pair waiting
    out_ready = 1'b0;
    send_ops(8'hFF, 8'hFF);
    expect_req("bp");
    @(posedge clk); #1;
    do_ack(16'hFE01);
    expect_out("bp");
    in_valid = 1'b1; in_a = 8'd2; in_b = 8'd3;
    req_q.push_back(16'h0203);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", out_data, 16'hFE01);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_no_req", req, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_txn_cnt", txn_cnt, 2);
    chk("bp_out_valid_clr", out_valid, 0);
    chk("bp_in_ready_back", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    expect_req("b2b");
    @(posedge clk); #1;
    do_ack(16'd6);
    expect_out("b2b");
    @(negedge clk);
    chk("b2b_txn_cnt", txn_cnt, 3);

    // Spurious ack in IDLE
    @(posedge clk); #1;
    ack = 1'b1; data_ack = 16'h1234;
    @(posedge clk); #1;
    ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_out_valid", out_valid, 0);
    chk("idle_ack_busy", busy, 0);
    chk("idle_ack_out_data", out_data, 16'd6);
    chk("idle_ack_txn_cnt", txn_cnt, 3);

    // Early ack in the ISSUE cycle
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 8'd5; in_b = 8'd7;
    req_q.push_back(16'h0507);
    @(posedge clk); #1;
    in_valid = 1'b0;
    ack = 1'b1; data_ack = 16'hBAD0;
    @(negedge clk);
    chk("early_req", req, 1);
    chk("early_data_req", data_req, req_q.pop_front());
    @(posedge clk); #1;
    ack = 1'b0;
    @(negedge clk);
    chk("early_out_valid", out_valid, 0);
    chk("early_busy", busy, 1);
    repeat (2) @(negedge clk);
    chk("early_still_wait", out_valid, 0);
    @(posedge clk); #1;
    do_ack(16'd35);
    expect_out("early");
    @(negedge clk);
    chk("early_txn_cnt", txn_cnt, 4);

    // Reset mid-WAIT, then a stale ack
    send_ops(8'd9, 8'd9);
    expect_req("midrst");
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_txn_cnt", txn_cnt, 0);
    chk("midrst_data_req", data_req, 0);
    chk("midrst_out_data", out_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ack = 1'b1; data_ack = 16'd81;
    @(posedge clk); #1;
    ack = 1'b0;
    @(negedge clk);
    chk("stale_ack_out_valid", out_valid, 0);
    chk("stale_ack_busy", busy, 0);
    chk("stale_ack_out_data", out_data, 0);

`ifdef MULT_REQ_TIMEOUT_EN
    // No ack: expect HOLD with all-ones after 8 WAIT cycles
    begin
      int n;
      n = 0;
      send_ops(8'd3, 8'd3);
      expect_req("tmo");
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        n++;
        if (out_valid) break;
      end
      chk("tmo_wait_cycles", n, 8);
      chk("tmo_out_valid", out_valid, 1);
      chk("tmo_err", timeout_err, 1);
      chk("tmo_out_data", out_data, 16'hFFFF);
      @(negedge clk);
      chk("tmo_err_sticky", timeout_err, 1);
      chk("tmo_txn_cnt", txn_cnt, 1);
    end
`endif

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
